// File: rtl/bsg_cgol_pkg.sv
// Shared types for the CGOL output path: serializer state encoding and beat-counter sizing.
package bsg_cgol_pkg;

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eSEND  = 2'd1,
    eTRAIL = 2'd2
  } ser_state_e;

  // Counter must reach beats (one past the last data beat) before the trailer.
  function automatic int beat_cnt_width(input int beats);
    return (beats < 1) ? 1 : $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/bsg_cgol_popcount.sv
// Combinational count of ones across a width_p-bit vector.
module bsg_cgol_popcount #(
  parameter int width_p = 64,
  localparam int count_w_lp = $clog2(width_p + 1)
) (
  input  logic [width_p-1:0]    data_i,
  output logic [count_w_lp-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < width_p; i++)
      count_o = count_o + count_w_lp'(data_i[i]);
  end

endmodule

// File: rtl/bsg_cgol_output_serializer.sv
// Captures a finished CGOL board and streams it out as data_width_p-bit beats, LSB first.
// Optional live-cell-count trailer beat enabled by defining BSG_CGOL_SER_POPCOUNT_EN.
//
//  state  | meaning
//  eIDLE  | no frame in flight, ready to capture a board
//  eSEND  | presenting data beat cnt_r of the captured board
//  eTRAIL | presenting the live-cell-count trailer beat
module bsg_cgol_output_serializer
  import bsg_cgol_pkg::*;
#(
  parameter int board_width_p  = 64,
  parameter int board_height_p = 64,
  parameter int data_width_p   = 64,
  localparam int cells_lp = board_width_p * board_height_p
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [cells_lp-1:0]     data_i,
  input  logic                    v_i,
  output logic                    yumi_o,
  output logic [data_width_p-1:0] data_o,
  output logic                    v_o,
  output logic                    last_o,
  input  logic                    ready_i
);

  localparam int beats_lp = cells_lp / data_width_p;
  localparam int cnt_w_lp = beat_cnt_width(beats_lp);
  localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(beats_lp - 1);

  if (cells_lp % data_width_p != 0) begin : g_bad_width
    $error("data_width_p must divide board_width_p*board_height_p");
  end

  ser_state_e          state_r, state_n;
  logic [cells_lp-1:0] shift_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                accept, final_accept, data_done;

  assign accept       = v_o & ready_i;
  assign final_accept = accept & last_o;
  assign data_done    = accept & (state_r == eSEND) & (cnt_r == last_beat_lp);
  assign yumi_o       = v_i & ((state_r == eIDLE) | final_accept);

`ifdef BSG_CGOL_SER_POPCOUNT_EN
  localparam int pop_w_lp  = $clog2(cells_lp + 1);
  localparam int beat_w_lp = $clog2(data_width_p + 1);

  if (pop_w_lp > data_width_p) begin : g_bad_pop
    $error("live-cell count does not fit in one data_width_p beat");
  end

  logic [pop_w_lp-1:0]  pop_r;
  logic [beat_w_lp-1:0] beat_pop;

  bsg_cgol_popcount #(.width_p(data_width_p)) u_popcount (
    .data_i (shift_r[data_width_p-1:0]),
    .count_o(beat_pop)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      pop_r <= '0;
    else if (yumi_o)
      pop_r <= '0;
    else if (accept && state_r == eSEND)
      pop_r <= pop_r + pop_w_lp'(beat_pop);
  end
`endif

  always_comb begin
    v_o    = (state_r != eIDLE);
    data_o = '0;
    last_o = 1'b0;
    case (state_r)
      eSEND: begin
        data_o = shift_r[data_width_p-1:0];
`ifndef BSG_CGOL_SER_POPCOUNT_EN
        last_o = (cnt_r == last_beat_lp);
`endif
      end
      eTRAIL: begin
`ifdef BSG_CGOL_SER_POPCOUNT_EN
        data_o = data_width_p'(pop_r);
        last_o = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
`ifdef BSG_CGOL_SER_POPCOUNT_EN
      eSEND:  if (data_done) state_n = eTRAIL;
`else
      eSEND:  if (data_done) state_n = eIDLE;
`endif
      eTRAIL: if (accept) state_n = eIDLE;
      default: ;
    endcase
    // A capture (idle or back-to-back on the final beat) always starts a new frame.
    if (yumi_o) state_n = eSEND;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eIDLE;
      shift_r <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      if (yumi_o) begin
        shift_r <= data_i;
        cnt_r   <= '0;
      end else if (accept && state_r == eSEND) begin
        shift_r <= shift_r >> data_width_p;
        cnt_r   <= cnt_r + cnt_w_lp'(1);
      end
    end
  end

endmodule

// File: tb/tb_bsg_cgol_output_serializer.sv
// Directed bench for the CGOL output serializer on a 4x4 board at beat widths 4, 8 and 16.
module tb_bsg_cgol_output_serializer;

`ifdef BSG_CGOL_SER_POPCOUNT_EN
  localparam int tr_lp = 1;
`else
  localparam int tr_lp = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] d4_data = '0;
  logic        d4_v = 1'b0, d4_ready = 1'b0;
  logic        d4_yumi, d4_vo, d4_last;
  logic [3:0]  d4_do;

  logic [15:0] d8_data = '0;
  logic        d8_v = 1'b0, d8_ready = 1'b1;
  logic        d8_yumi, d8_vo, d8_last;
  logic [7:0]  d8_do;

  logic [15:0] d16_data = '0;
  logic        d16_v = 1'b0, d16_ready = 1'b1;
  logic        d16_yumi, d16_vo, d16_last;
  logic [15:0] d16_do;

  int checks = 0;
  int errors = 0;

  bsg_cgol_output_serializer #(.board_width_p(4), .board_height_p(4), .data_width_p(4)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n), .data_i(d4_data), .v_i(d4_v), .yumi_o(d4_yumi),
    .data_o(d4_do), .v_o(d4_vo), .last_o(d4_last), .ready_i(d4_ready));

  bsg_cgol_output_serializer #(.board_width_p(4), .board_height_p(4), .data_width_p(8)) dut8 (
    .clk_i(clk), .reset_n_i(reset_n), .data_i(d8_data), .v_i(d8_v), .yumi_o(d8_yumi),
    .data_o(d8_do), .v_o(d8_vo), .last_o(d8_last), .ready_i(d8_ready));

  bsg_cgol_output_serializer #(.board_width_p(4), .board_height_p(4), .data_width_p(16)) dut16 (
    .clk_i(clk), .reset_n_i(reset_n), .data_i(d16_data), .v_i(d16_v), .yumi_o(d16_yumi),
    .data_o(d16_do), .v_o(d16_vo), .last_o(d16_last), .ready_i(d16_ready));

  task automatic test_reset;
    #3;
    checks++; if (d4_vo !== 1'b0)   begin errors++; $display("FAIL reset v_o: got %b want 0", d4_vo); end
    checks++; if (d4_last !== 1'b0) begin errors++; $display("FAIL reset last_o: got %b want 0", d4_last); end
    checks++; if (d4_yumi !== 1'b0) begin errors++; $display("FAIL reset yumi_o: got %b want 0", d4_yumi); end
    checks++; if (d4_do !== 4'h0)   begin errors++; $display("FAIL reset data_o: got %h want 0", d4_do); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (d4_vo !== 1'b0) begin errors++; $display("FAIL idle after reset v_o: got %b want 0", d4_vo); end
  endtask

  task automatic test_basic;
    logic [3:0] exp [5];
    exp = '{4'h3, 4'hC, 4'h5, 4'hA, 4'h8};
    @(posedge clk); #1; d4_data = 16'hA5C3; d4_v = 1'b1; d4_ready = 1'b1;
    @(negedge clk);
    checks++; if (d4_yumi !== 1'b1 || d4_vo !== 1'b0) begin
      errors++; $display("FAIL basic capture: yumi=%b v=%b want yumi=1 v=0", d4_yumi, d4_vo); end
    @(posedge clk); #1; d4_v = 1'b0; d4_data = '0;
    for (int k = 0; k < 4 + tr_lp; k++) begin
      @(negedge clk);
      checks++; if (d4_vo !== 1'b1 || d4_do !== exp[k] || d4_last !== (k == 3 + tr_lp)) begin
        errors++; $display("FAIL basic beat %0d: v=%b data=%h last=%b want v=1 data=%h last=%b",
                           k, d4_vo, d4_do, d4_last, exp[k], (k == 3 + tr_lp)); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (d4_vo !== 1'b0) begin errors++; $display("FAIL basic end idle: v=%b want 0", d4_vo); end
  endtask

  task automatic test_stall;
    logic [3:0] exp [5];
    logic [3:0] prev_d;
    logic       prev_l, stalled;
    int         idx, cyc;
    exp = '{4'h3, 4'hC, 4'h5, 4'hA, 4'h8};
    idx = 0; cyc = 0; stalled = 1'b0; prev_d = '0; prev_l = 1'b0;
    @(posedge clk); #1; d4_data = 16'hA5C3; d4_v = 1'b1;
    @(posedge clk); #1; d4_v = 1'b0;
    while (idx < 4 + tr_lp && cyc < 40) begin
      d4_ready = (cyc % 3 == 0);
      @(negedge clk);
      if (d4_vo !== 1'b1) begin
        checks++; errors++; $display("FAIL stall gap at cycle %0d: v=%b want 1", cyc, d4_vo);
      end else begin
        if (stalled) begin
          checks++; if (d4_do !== prev_d || d4_last !== prev_l) begin
            errors++; $display("FAIL stall hold: data=%h last=%b want data=%h last=%b", d4_do, d4_last, prev_d, prev_l); end
        end
        if (d4_ready) begin
          checks++; if (d4_do !== exp[idx] || d4_last !== (idx == 3 + tr_lp)) begin
            errors++; $display("FAIL stall beat %0d: data=%h last=%b want data=%h last=%b",
                               idx, d4_do, d4_last, exp[idx], (idx == 3 + tr_lp)); end
          idx++;
        end
        stalled = !d4_ready; prev_d = d4_do; prev_l = d4_last;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (idx != 4 + tr_lp) begin errors++; $display("FAIL stall timeout: beats=%0d want %0d", idx, 4 + tr_lp); end
    d4_ready = 1'b1;
    @(negedge clk);
    checks++; if (d4_vo !== 1'b0) begin errors++; $display("FAIL stall end idle: v=%b want 0", d4_vo); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp [10];
    int n;
    n = 4 + tr_lp;
    if (tr_lp == 1) exp = '{4'h3, 4'hC, 4'h5, 4'hA, 4'h8, 4'hF, 4'h0, 4'hF, 4'h0, 4'h8};
    else            exp = '{4'h3, 4'hC, 4'h5, 4'hA, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
    @(posedge clk); #1; d4_data = 16'hA5C3; d4_v = 1'b1; d4_ready = 1'b1;
    @(posedge clk); #1; d4_data = 16'h0F0F;
    for (int j = 0; j < 2 * n; j++) begin
      @(negedge clk);
      checks++; if (d4_vo !== 1'b1 || d4_do !== exp[j] || d4_last !== (j == n - 1 || j == 2 * n - 1) ||
                    d4_yumi !== (j == n - 1)) begin
        errors++; $display("FAIL b2b beat %0d: v=%b data=%h last=%b yumi=%b want v=1 data=%h last=%b yumi=%b",
                           j, d4_vo, d4_do, d4_last, d4_yumi, exp[j], (j == n - 1 || j == 2 * n - 1), (j == n - 1)); end
      @(posedge clk); #1;
      if (j == n - 1) begin d4_v = 1'b0; d4_data = '0; end
    end
    @(negedge clk);
    checks++; if (d4_vo !== 1'b0) begin errors++; $display("FAIL b2b end idle: v=%b want 0", d4_vo); end
  endtask

  task automatic test_reset_mid_frame;
    int cyc;
    @(posedge clk); #1; d4_data = 16'hA5C3; d4_v = 1'b1; d4_ready = 1'b1;
    @(posedge clk); #1; d4_v = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (d4_vo !== 1'b1 || d4_do !== 4'hA) begin
      errors++; $display("FAIL midreset pre: v=%b data=%h want v=1 data=a", d4_vo, d4_do); end
    #1; reset_n = 1'b0; #1;
    checks++; if (d4_vo !== 1'b0 || d4_last !== 1'b0 || d4_yumi !== 1'b0 || d4_do !== 4'h0) begin
      errors++; $display("FAIL midreset async: v=%b last=%b yumi=%b data=%h want all 0", d4_vo, d4_last, d4_yumi, d4_do); end
    @(posedge clk); @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (d4_vo !== 1'b0) begin errors++; $display("FAIL midreset released: v=%b want 0", d4_vo); end
    d4_data = 16'h0F0F; d4_v = 1'b1;
    @(negedge clk);
    checks++; if (d4_yumi !== 1'b1) begin errors++; $display("FAIL midreset recapture yumi: got %b want 1", d4_yumi); end
    @(posedge clk); #1; d4_v = 1'b0;
    @(negedge clk);
    checks++; if (d4_vo !== 1'b1 || d4_do !== 4'hF || d4_last !== 1'b0) begin
      errors++; $display("FAIL midreset beat0: v=%b data=%h last=%b want v=1 data=f last=0", d4_vo, d4_do, d4_last); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (d4_do !== 4'h0) begin errors++; $display("FAIL midreset beat1: data=%h want 0", d4_do); end
    cyc = 0;
    while (d4_vo === 1'b1 && cyc < 10) begin @(posedge clk); #1; @(negedge clk); cyc++; end
    checks++; if (d4_vo !== 1'b0) begin errors++; $display("FAIL midreset drain timeout: v=%b want 0", d4_vo); end
  endtask

  task automatic test_width8;
    logic [7:0] exp [3];
    exp = '{8'hFF, 8'hFF, 8'h10};
    @(posedge clk); #1; d8_data = 16'hFFFF; d8_v = 1'b1;
    @(negedge clk);
    checks++; if (d8_yumi !== 1'b1) begin errors++; $display("FAIL w8 yumi: got %b want 1", d8_yumi); end
    @(posedge clk); #1; d8_v = 1'b0;
    for (int k = 0; k < 2 + tr_lp; k++) begin
      @(negedge clk);
      checks++; if (d8_vo !== 1'b1 || d8_do !== exp[k] || d8_last !== (k == 1 + tr_lp)) begin
        errors++; $display("FAIL w8 beat %0d: v=%b data=%h last=%b want v=1 data=%h last=%b",
                           k, d8_vo, d8_do, d8_last, exp[k], (k == 1 + tr_lp)); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (d8_vo !== 1'b0) begin errors++; $display("FAIL w8 end idle: v=%b want 0", d8_vo); end
  endtask

  task automatic test_single_beat;
    logic [15:0] exp [2];
    exp = '{16'h1234, 16'h0005};
    @(posedge clk); #1; d16_data = 16'h1234; d16_v = 1'b1;
    @(posedge clk); #1; d16_v = 1'b0;
    for (int k = 0; k < 1 + tr_lp; k++) begin
      @(negedge clk);
      checks++; if (d16_vo !== 1'b1 || d16_do !== exp[k] || d16_last !== (k == tr_lp)) begin
        errors++; $display("FAIL w16 beat %0d: v=%b data=%h last=%b want v=1 data=%h last=%b",
                           k, d16_vo, d16_do, d16_last, exp[k], (k == tr_lp)); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (d16_vo !== 1'b0) begin errors++; $display("FAIL w16 end idle: v=%b want 0", d16_vo); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
    test_width8();
    test_single_beat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
